// File: rtl/data_memory_dump.sv
// Word-addressed data memory for the MEM-stage port plus a dump engine that streams every word out
// over a valid/ready port. Optional build macro DUMP_SKIP_ZERO_EN makes the engine skip zero words.
module data_memory_dump #(
  parameter int N          = 64,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  memWrite,
  input  logic                  memRead,
  input  logic [N-1:0]          address,
  input  logic [N-1:0]          writeData,
  output logic [N-1:0]          readData,
  input  logic                  dump,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [DEPTH_LOG2-1:0] dump_addr,
  output logic [N-1:0]          dump_data,
  output logic                  dump_busy,
  output logic                  dump_done
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [DEPTH_LOG2-1:0]   ptr_reg, ptr_next;
  logic                    dump_prev_reg;
  logic [N-1:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   idx;
  logic [N-1:0]            scan_word;
  logic                    advance;
  logic                    unused_addr_bits;

  // 8-byte words: low three bits select a byte inside the word, high bits wrap.
  assign idx              = address[DEPTH_LOG2+2:3];
  assign unused_addr_bits = ^{address[N-1:DEPTH_LOG2+3], address[2:0]};
  assign scan_word        = mem[ptr_reg];
  assign readData         = memRead ? mem[idx] : '0;

  // Registers rather than block RAM: reset must clear every word in one edge.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (memWrite) begin
      mem[idx] <= writeData;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      dump_prev_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      dump_prev_reg <= dump;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    dump_valid = 1'b0;
    dump_busy  = 1'b0;
    dump_done  = 1'b0;
    dump_addr  = '0;
    dump_data  = '0;
    advance    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dump && !dump_prev_reg) begin
          state_next = SCAN;
          ptr_next   = '0;
        end
      end
      SCAN: begin
        dump_busy = 1'b1;
        dump_addr = ptr_reg;
`ifdef DUMP_SKIP_ZERO_EN
        if (scan_word == '0) begin
          advance = 1'b1;
        end else begin
          dump_valid = 1'b1;
          dump_data  = scan_word;
          advance    = dump_ready;
        end
`else
        dump_valid = 1'b1;
        dump_data  = scan_word;
        advance    = dump_ready;
`endif
        if (advance) begin
          if (ptr_reg == '1) begin
            state_next = DONE;
          end else begin
            ptr_next = ptr_reg + 1'b1;
          end
        end
      end
      DONE: begin
        dump_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_memory_dump.sv
// Scoreboard bench for data_memory_dump: loads and dump beats are predicted from a word array
// model and checked by a monitor on the falling edge.
module tb_data_memory_dump;

  typedef struct {
    logic [5:0]  addr;
    logic [63:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memWrite = 1'b0;
  logic        memRead = 1'b0;
  logic [63:0] address = '0;
  logic [63:0] writeData = '0;
  logic [63:0] readData;
  logic        dump = 1'b0;
  logic        dump_valid;
  logic        dump_ready = 1'b1;
  logic [5:0]  dump_addr;
  logic [63:0] dump_data;
  logic        dump_busy;
  logic        dump_done;

  logic [63:0] model [64];
  beat_t       exp_q[$];
  logic [63:0] load_q[$];
  int          n_compared = 0;
  int          n_mismatch = 0;
  int          done_cnt = 0;
  int          beats_cnt = 0;

  data_memory_dump #(.N(64), .DEPTH_LOG2(6)) dut (
    .CLOCK_50(clk), .reset(reset), .memWrite(memWrite), .memRead(memRead),
    .address(address), .writeData(writeData), .readData(readData),
    .dump(dump), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_busy(dump_busy), .dump_done(dump_done)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_compared++;
    n_mismatch++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference memory: commits stores on the rising edge and refreshes pending beats.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 64; i++) model[i] = '0;
      exp_q.delete();
    end else if (memWrite) begin
      model[address[8:3]] = writeData;
      foreach (exp_q[j]) if (exp_q[j].addr == address[8:3]) exp_q[j].data = writeData;
    end
  end

  // Monitor.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (memRead) begin
        if (load_q.size() == 0) fail_now("load_unexpected");
        else check("load", readData, load_q.pop_front());
      end else begin
        check("read_idle", readData, 64'd0);
      end
      if (dump_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("beat_extra");
        end else begin
          check("beat_addr", {58'd0, dump_addr}, {58'd0, exp_q[0].addr});
          check("beat_data", dump_data, exp_q[0].data);
          if (dump_ready) begin
            void'(exp_q.pop_front());
            beats_cnt++;
            $display("beat addr=%0d data=%0h", dump_addr, dump_data);
          end
        end
      end
      if (dump_done) begin
        done_cnt++;
        check("done_queue_empty", 64'(exp_q.size()), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [63:0] a, input logic [63:0] d);
    memWrite = 1'b1; address = a; writeData = d;
    tick();
    memWrite = 1'b0;
    $display("store addr=%0h data=%0h", a, d);
  endtask

  task automatic load(input logic [63:0] a);
    memRead = 1'b1; address = a;
    load_q.push_back(model[a[8:3]]);
    tick();
    memRead = 1'b0;
    $display("load addr=%0h", a);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  // Every word in index order; with zero skipping only nonzero words are beats.
  task automatic start_dump(output int n_exp);
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
`ifdef DUMP_SKIP_ZERO_EN
      if (model[i] != 0) exp_q.push_back('{addr: 6'(i), data: model[i]});
`else
      exp_q.push_back('{addr: 6'(i), data: model[i]});
`endif
    end
    n_exp = exp_q.size();
    dump = 1'b1;
  endtask

  task automatic wait_done(input int budget, input bit rand_io);
    int d0 = done_cnt;
    int k;
    for (k = 0; k < budget; k++) begin
      if (rand_io) begin
        dump_ready = 1'($urandom_range(0, 1));
        memRead = 1'($urandom_range(0, 1));
        address = {$urandom, $urandom};
        if (memRead) load_q.push_back(model[address[8:3]]);
      end
      tick();
      memRead = 1'b0;
      if (done_cnt != d0) break;
    end
    dump_ready = 1'b1;
    if (k == budget) fail_now("dump_timeout");
  endtask

  task automatic fill_nonzero();
    for (int i = 0; i < 64; i++) store(64'(i * 8 + $urandom_range(0, 7)), {$urandom, $urandom} | 64'd1);
  endtask

  initial begin
    int n_exp, b0, d0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", {63'd0, dump_valid}, 64'd0);
    check("rst_busy", {63'd0, dump_busy}, 64'd0);
    check("rst_done", {63'd0, dump_done}, 64'd0);
    check("rst_addr", {58'd0, dump_addr}, 64'd0);
    check("rst_data", dump_data, 64'd0);
    tick();
    load(64'h10);

    // Misaligned and wrapped addresses land on the same word.
    store(64'h10, 64'hDEAD_BEEF);
    load(64'h10);
    load(64'h13);
    load(64'h210);

    for (int i = 0; i < 200; i++) begin
      memWrite = 1'($urandom_range(0, 1));
      memRead = 1'($urandom_range(0, 1));
      address = {$urandom, $urandom};
      writeData = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      if (memRead) load_q.push_back(model[address[8:3]]);
      tick();
    end
    memWrite = 1'b0; memRead = 1'b0;

    // Two nonzero words, ready held high.
    do_reset();
    store(64'd8, 64'd5);
    store(64'd24, 64'd7);
    b0 = beats_cnt; d0 = done_cnt;
    start_dump(n_exp);
    tick();
    @(negedge clk);
    check("dump_latency_busy", {63'd0, dump_busy}, 64'd1);
    dump = 1'b0;
    wait_done(200, 1'b0);
`ifdef DUMP_SKIP_ZERO_EN
    check("beats_two_words", 64'(beats_cnt - b0), 64'd2);
`else
    check("beats_two_words", 64'(beats_cnt - b0), 64'd64);
`endif
    check("done_two_words", 64'(done_cnt - d0), 64'd1);
    tick();

    // Random backpressure with concurrent loads.
    fill_nonzero();
    b0 = beats_cnt; d0 = done_cnt;
    start_dump(n_exp);
    tick();
    dump = 1'b0;
    wait_done(1000, 1'b1);
    check("beats_random_ready", 64'(beats_cnt - b0), 64'(n_exp));
    check("done_random_ready", 64'(done_cnt - d0), 64'd1);
    tick();

    // Level held high with a second edge mid-scan.
    b0 = beats_cnt; d0 = done_cnt;
    start_dump(n_exp);
    for (int c = 0; c < 200; c++) begin
      if (c == 20) dump = 1'b0;
      if (c == 21) dump = 1'b1;
      tick();
    end
    dump = 1'b0;
    check("beats_held", 64'(beats_cnt - b0), 64'(n_exp));
    check("done_held", 64'(done_cnt - d0), 64'd1);
    tick();

    // Reset while presenting word 20.
    start_dump(n_exp);
    tick();
    dump = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #1;
      if (dump_valid && dump_addr == 6'd20) break;
    end
    d0 = done_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", {63'd0, dump_busy}, 64'd0);
    check("abort_valid", {63'd0, dump_valid}, 64'd0);
    check("abort_done", {63'd0, dump_done}, 64'd0);
    repeat (5) tick();
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    for (int i = 0; i < 64; i++) load(64'(i * 8));

    // Stores racing the scan: word 2 in its handshake cycle, word 10 ahead of the pointer.
    fill_nonzero();
    b0 = beats_cnt; d0 = done_cnt;
    start_dump(n_exp);
    tick();
    dump = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #1;
      if (dump_valid && dump_addr == 6'd2) break;
    end
    memWrite = 1'b1; address = 64'd16; writeData = 64'd9;
    tick();
    address = 64'd80;
    tick();
    memWrite = 1'b0;
    wait_done(200, 1'b0);
    check("beats_live", 64'(beats_cnt - b0), 64'(n_exp));
    check("done_live", 64'(done_cnt - d0), 64'd1);
    load(64'd16);
    load(64'd80);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
